// File: rtl/exu_div_if.sv
// Request/response bundle between the ex stage and the iterative divider.
// Handshake is shared with the execute-stage multiplier.
interface exu_div_if #(
  parameter int REG_DATA_WIDTH = 32
);
  logic [REG_DATA_WIDTH-1:0] dividend_i;
  logic [REG_DATA_WIDTH-1:0] divisor_i;
  logic                      start_i;
  logic [3:0]                op_i;
  logic [REG_DATA_WIDTH-1:0] result_o;
  logic                      busy_o;
  logic                      valid_o;

  modport master (
    output dividend_i, divisor_i, start_i, op_i,
    input  result_o, busy_o, valid_o
  );

  modport slave (
    input  dividend_i, divisor_i, start_i, op_i,
    output result_o, busy_o, valid_o
  );
endinterface

// File: rtl/exu_div.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: 32 iterations on
// operand magnitudes, sign fix-up at the end, single-cycle zero/overflow path.
module exu_div (
  input  logic      clk,
  input  logic      rst_n,
  exu_div_if.slave  bus
);
  localparam int W = 32;

  typedef enum logic [1:0] {IDLE, CALC, OUTPUT} state_e;

  state_e         state_q,   state_d;
  logic [W-1:0]   result_q,  result_d;
  logic           busy_q,    busy_d;
  logic           valid_q,   valid_d;
  logic           signed_q,  signed_d;
  logic           sel_rem_q, sel_rem_d;
  logic           sign_a_q,  sign_a_d;
  logic           sign_b_q,  sign_b_d;
  logic           dz_q,      dz_d;
  logic           ovf_q,     ovf_d;
  logic [W-1:0]   dvd_q,     dvd_d;
  logic [W-1:0]   dvs_q,     dvs_d;
  logic [W-1:0]   quo_q,     quo_d;
  logic [W:0]     prem_q,    prem_d;
  logic [4:0]     count_q,   count_d;

  logic           op_divu, op_rem, op_remu, op_signed, op_sel_rem;
  logic           a_neg, b_neg, div_zero, div_ovf;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     prem_shift, prem_sub;
  logic           prem_ge;
  logic [W-1:0]   quo_fix, rem_fix, quo_out, rem_out;

  // Unrecognised op encodings fall through to signed DIV.
  assign op_divu    = (bus.op_i == 4'b0010);
  assign op_rem     = (bus.op_i == 4'b0100);
  assign op_remu    = (bus.op_i == 4'b1000);
  assign op_signed  = !(op_divu || op_remu);
  assign op_sel_rem = op_rem || op_remu;

  assign a_neg    = op_signed && bus.dividend_i[W-1];
  assign b_neg    = op_signed && bus.divisor_i[W-1];
  assign a_mag    = a_neg ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
  assign b_mag    = b_neg ? (~bus.divisor_i + 1'b1)  : bus.divisor_i;
  assign div_zero = (bus.divisor_i == '0);
  assign div_ovf  = op_signed && (bus.dividend_i == {1'b1, {(W-1){1'b0}}})
                    && (bus.divisor_i == '1);

  assign prem_shift = {prem_q[W-1:0], dvd_q[W-1]};
  assign prem_sub   = prem_shift - {1'b0, dvs_q};
  assign prem_ge    = (prem_shift >= {1'b0, dvs_q});

  assign quo_fix = (sign_a_q ^ sign_b_q) ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = sign_a_q ? (~prem_q[W-1:0] + 1'b1) : prem_q[W-1:0];

  always_comb begin
    quo_out = quo_fix;
    rem_out = rem_fix;
    if (dz_q) begin
      // dvd_q holds the raw dividend on the fast path.
      quo_out = '1;
      rem_out = dvd_q;
    end else if (ovf_q) begin
      quo_out = {1'b1, {(W-1){1'b0}}};
      rem_out = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    signed_d  = signed_q;
    sel_rem_d = sel_rem_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    prem_d    = prem_q;
    count_d   = count_q;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (!bus.start_i) begin
          busy_d = 1'b0;
        end else begin
          busy_d    = 1'b1;
          signed_d  = op_signed;
          sel_rem_d = op_sel_rem;
          sign_a_d  = a_neg;
          sign_b_d  = b_neg;
          dz_d      = div_zero;
          ovf_d     = div_ovf;
          if (div_zero || div_ovf) begin
            dvd_d   = bus.dividend_i;
            state_d = OUTPUT;
          end else begin
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            quo_d   = '0;
            prem_d  = '0;
            count_d = '0;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (!bus.start_i) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          dvd_d   = {dvd_q[W-2:0], 1'b0};
          prem_d  = prem_ge ? prem_sub : prem_shift;
          quo_d   = {quo_q[W-2:0], prem_ge};
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d = OUTPUT;
          end
        end
      end

      OUTPUT: begin
        result_d = sel_rem_q ? rem_out : quo_out;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      signed_q  <= 1'b0;
      sel_rem_q <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      prem_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      signed_q  <= signed_d;
      sel_rem_q <= sel_rem_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      prem_q    <= prem_d;
      count_q   <= count_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.busy_o   = busy_q;
  assign bus.valid_o  = valid_q;
endmodule

// File: tb/tb_exu_div.sv
// Self-checking bench for exu_div: expected results are queued at start and
// popped by a monitor whenever valid_o is seen.
module tb_exu_div;
  logic clk;
  logic rst_n;
  exu_div_if #(.REG_DATA_WIDTH(32)) bus ();

  exu_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [3:0] OP_DIV  = 4'b0001;
  localparam logic [3:0] OP_DIVU = 4'b0010;
  localparam logic [3:0] OP_REM  = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b1000;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] last_exp = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every valid_o must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n && bus.valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid result=%h with empty scoreboard", bus.result_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.result_o !== mon_exp) begin
          errors++;
          $display("FAIL result got=%h exp=%h", bus.result_o, mon_exp);
        end else begin
          $display("txn result=%h ok", bus.result_o);
        end
      end
    end
  end

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic   is_signed, want_rem;
    longint sa, sb, q, r;
    want_rem  = (op == OP_REM) || (op == OP_REMU);
    is_signed = !((op == OP_DIVU) || (op == OP_REMU));
    if (b == 32'h0) return want_rem ? a : 32'hFFFF_FFFF;
    if (is_signed) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return want_rem ? r[31:0] : q[31:0];
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    logic is_signed;
    is_signed = !((op == OP_DIVU) || (op == OP_REMU));
    if (b == 32'h0) return 1;
    if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string name);
    int lat;
    int busy_n;
    bit seen;
    @(negedge clk);
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.start_i    = 1'b1;
    exp_q.push_back(exp);
    last_exp = exp;
    lat = 0;
    busy_n = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.busy_o) busy_n++;
      if (bus.valid_o) seen = 1;
    end
    bus.start_i = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout no valid_o within 40 cycles", name);
      exp_q.delete();
    end
    checks++;
    if (lat - 1 != exp_lat) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=%0d", name, lat - 1, exp_lat);
    end
    checks++;
    if (busy_n != exp_lat) begin
      errors++;
      $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_n, exp_lat);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s after_valid valid=%b busy=%b exp 0 0", name, bus.valid_o, bus.busy_o);
    end
    $display("txn %s op=%b a=%h b=%h exp=%h lat=%0d", name, op, a, b, exp, lat - 1);
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.start_i    = 1'b0;
    bus.op_i       = OP_DIV;
    bus.dividend_i = 32'h0;
    bus.divisor_i  = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.result_o !== 32'h0 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset result=%h busy=%b valid=%b exp 0 0 0",
               bus.result_o, bus.busy_o, bus.valid_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b valid=%b exp 0 0", bus.busy_o, bus.valid_o);
    end
    $display("txn reset done");
  endtask

  task automatic test_signed();
    logic [3:0]  ops [5] = '{OP_DIV, OP_REM, OP_REM, OP_DIV, 4'b0000};
    logic [31:0] as  [5] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100};
    logic [31:0] bs  [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd2, 32'd2, 32'hFFFF_FFF9};
    logic [31:0] es  [5] = '{32'hFFFF_FFF2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF2};
    for (int i = 0; i < 5; i++) do_op(ops[i], as[i], bs[i], es[i], 33, "signed");
  endtask

  task automatic test_unsigned();
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33, "divu");
    do_op(OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 33, "remu");
    do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, "divu_no_ovf");
  endtask

  task automatic test_fast_path();
    do_op(OP_DIV,  32'h1234, 32'h0, 32'hFFFF_FFFF, 1, "div_by_zero");
    do_op(OP_REMU, 32'h1234, 32'h0, 32'h0000_1234, 1, "remu_by_zero");
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf");
  endtask

  task automatic test_random();
    logic [3:0]  op_tab [4] = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = op_tab[$urandom_range(0, 3)];
      a  = $urandom;
      b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 3 == 0) b = ~b + 32'd1;
      do_op(op, a, b, model(op, a, b), model_lat(op, a, b), "random");
    end
  endtask

  task automatic test_abort();
    bit seen_valid;
    @(negedge clk);
    bus.op_i       = OP_DIVU;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd3;
    bus.start_i    = 1'b1;
    repeat (10) @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL abort busy=%b valid=%b exp 0 0", bus.busy_o, bus.valid_o);
    end
    checks++;
    if (bus.result_o !== last_exp) begin
      errors++;
      $display("FAIL abort_result got=%h exp=%h", bus.result_o, last_exp);
    end
    seen_valid = 0;
    repeat (35) begin
      @(negedge clk);
      if (bus.valid_o) seen_valid = 1;
    end
    checks++;
    if (seen_valid) begin
      errors++;
      $display("FAIL abort_no_valid got=1 exp=0");
    end
    $display("txn abort done");
    do_op(OP_DIVU, 32'd7, 32'd2, 32'd3, 33, "after_abort");
  endtask

  task automatic test_async_reset();
    bit seen_valid;
    @(negedge clk);
    bus.op_i       = OP_DIV;
    bus.dividend_i = 32'd12345;
    bus.divisor_i  = 32'd7;
    bus.start_i    = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.result_o !== 32'h0 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset result=%h busy=%b valid=%b exp 0 0 0",
               bus.result_o, bus.busy_o, bus.valid_o);
    end
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o || bus.busy_o) seen_valid = 1;
    end
    checks++;
    if (seen_valid) begin
      errors++;
      $display("FAIL async_reset_quiet activity after reset exp none");
    end
    $display("txn async_reset done");
  endtask

  task automatic test_back_to_back();
    int lat;
    bit seen;
    @(negedge clk);
    bus.op_i       = OP_DIVU;
    bus.dividend_i = 32'd100;
    bus.divisor_i  = 32'd7;
    bus.start_i    = 1'b1;
    exp_q.push_back(32'd14);
    lat = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.valid_o) seen = 1;
    end
    checks++;
    if (!seen || lat - 1 != 33) begin
      errors++;
      $display("FAIL b2b_first latency got=%0d seen=%b exp=33", lat - 1, seen);
    end
    // Keep start high through the valid cycle with the next operands.
    bus.op_i       = OP_DIV;
    bus.dividend_i = 32'hFFFF_FF9C;
    bus.divisor_i  = 32'd7;
    exp_q.push_back(32'hFFFF_FFF2);
    lat = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        checks++;
        if (bus.busy_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_no_gap busy got=%b exp=1", bus.busy_o);
        end
      end
      if (bus.valid_o) seen = 1;
    end
    bus.start_i = 1'b0;
    checks++;
    if (!seen || lat - 1 != 33) begin
      errors++;
      $display("FAIL b2b_second latency got=%0d seen=%b exp=33", lat - 1, seen);
      exp_q.delete();
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end valid=%b busy=%b exp 0 0", bus.valid_o, bus.busy_o);
    end
    $display("txn back_to_back done");
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_fast_path();
    test_random();
    test_abort();
    test_async_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
